add_mon_checker: RTL

Synthesizable monitor/checker for the registered-adder interface. It is the observing end of the a/b -> c path, the counterpart to the stimulus driver. It samples operands a, b each cycle and predicts c = (a + b) mod 2^W after LAT cycles. It compares the prediction against the DUT's c, and keeps check/error counters plus a first-mismatch capture. It sits beside the adder in the tb/emulation harness, on the same clock.

---
 rtl/add_mon_checker.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/add_mon_checker.sv
// -----------------------------------------------------------------------------
// add_mon_checker
//
// Purpose:
//   Observing end of the registered-adder a/b -> c path. Every cycle the
//   operands a and b are sampled. For each sample taken with en=1, the
//   truncated sum (a + b) mod 2^W is predicted to appear on c exactly LAT
//   cycles later. The prediction is compared against the DUT's c. The block
//   keeps saturating check/error counters, a one-cycle error pulse, a sticky
//   error flag and a capture of the first mismatching expected/actual pair.
//
// Optional feature:
//   ADD_MON_STOP_ON_ERR_EN - when defined, the first mismatch moves the FSM
//   to HALT. While halted no further compares happen and the statistics
//   freeze. The sample pipeline keeps shifting. Only rst or clr leave HALT.
//   When undefined, HALT is never entered.
//
// Parameters:
//   W     - operand/result width (c is the truncated sum)
//   LAT   - DUT latency in cycles, legal 1..4
//   CNT_W - width of the check and error counters
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset (priority over clr)
//   en         in   sample qualifier: a/b this cycle form a transaction
//   a, b       in   operands as seen at the DUT input
//   c          in   DUT result
//   clr        in   synchronous clear of statistics and pipeline
//   state      out  0 IDLE, 1 PRIME, 2 CHECK, 3 HALT
//   check_cnt  out  number of compares performed (saturating)
//   err_cnt    out  number of mismatches (saturating)
//   err_pulse  out  one-cycle pulse on each mismatch
//   sticky_err out  set on first mismatch, held until rst or clr
//   first_exp  out  expected value at the first mismatch
//   first_act  out  actual c at the first mismatch
// -----------------------------------------------------------------------------
module add_mon_checker #(
    parameter int W     = 1,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic             clr,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_pulse,
    output logic             sticky_err,
    output logic [W-1:0]     first_exp,
    output logic [W-1:0]     first_act
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

`ifdef ADD_MON_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,      state_d;
    logic [LAT-1:0]   vpipe_q,      vpipe_d;
    logic [W-1:0]     epipe_q [LAT];
    logic [W-1:0]     epipe_d [LAT];
    logic [CNT_W-1:0] check_cnt_q,  check_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;
    logic             err_pulse_q,  err_pulse_d;
    logic             sticky_q,     sticky_d;
    logic [W-1:0]     first_exp_q,  first_exp_d;
    logic [W-1:0]     first_act_q,  first_act_d;

    logic [W-1:0]     sum_w;
    logic             cmp_edge;
    logic             mismatch;
    logic             pipe_busy;

    // The carry out of a + b is deliberately dropped: the adder under test
    // produces a W-bit result.
    assign sum_w = a + b;

    // A compare happens whenever a valid sample reaches the last tap, unless
    // checking has been halted. The FSM state is not otherwise consulted, so
    // no valid sample is ever skipped.
    assign cmp_edge  = vpipe_q[LAT-1] && (state_q != S_HALT);
    // Case inequality so an X on c in simulation counts as a mismatch.
    assign mismatch  = cmp_edge && (c !== epipe_q[LAT-1]);
    assign pipe_busy = |vpipe_q;

    // -------------------------------------------------------------------------
    // Pipeline shift: taps advance every cycle, bubbles included.
    // -------------------------------------------------------------------------
    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = en;
        for (int i = 1; i < LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        epipe_d[0] = sum_w;
        for (int i = 1; i < LAT; i++) begin
            epipe_d[i] = epipe_q[i-1];
        end
    end

    // -------------------------------------------------------------------------
    // Statistics and first-mismatch capture
    // -------------------------------------------------------------------------
    always_comb begin
        check_cnt_d = check_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        sticky_d    = sticky_q;
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;

        if (cmp_edge) begin
            check_cnt_d = sat_inc(check_cnt_q);
            if (mismatch) begin
                err_cnt_d   = sat_inc(err_cnt_q);
                err_pulse_d = 1'b1;
                sticky_d    = 1'b1;
                // Only the very first mismatch since rst/clr is captured.
                if (!sticky_q) begin
                    first_exp_d = epipe_q[LAT-1];
                    first_act_d = c;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                // The first valid reaching the last tap is the first compare.
                if (cmp_edge) begin
                    state_d = (STOP_ON_ERR && mismatch) ? S_HALT : S_CHECK;
                end else if (!pipe_busy && !en) begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (STOP_ON_ERR && mismatch) begin
                    state_d = S_HALT;
                end else if (!pipe_busy && !en) begin
                    // Bubbles keep us in CHECK while anything is in flight.
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. rst and clr have the same effect on every register, so the
    // rst-over-clr priority needs no separate branch. A clear discards any
    // compare that coincides with it and drops everything in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= S_IDLE;
            vpipe_q     <= '0;
            check_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            sticky_q    <= 1'b0;
            first_exp_q <= '0;
            first_act_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                epipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            vpipe_q     <= vpipe_d;
            check_cnt_q <= check_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            sticky_q    <= sticky_d;
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
            for (int i = 0; i < LAT; i++) begin
                epipe_q[i] <= epipe_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign state      = state_q;
    assign check_cnt  = check_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err_pulse  = err_pulse_q;
    assign sticky_err = sticky_q;
    assign first_exp  = first_exp_q;
    assign first_act  = first_act_q;

endmodule
